// File: rtl/session_checker_if.sv
// session_checker_if: groups the start/symbol inputs and the session status
// outputs of session_checker. The master drives symbols, the slave checks them.
interface session_checker_if;
    logic       start;
    logic       sym_valid;
    logic [1:0] sym;
    logic       busy;
    logic [1:0] sym_idx;
    logic       pass;
    logic       fail;

    modport master (
        output start, sym_valid, sym,
        input  busy, sym_idx, pass, fail
    );

    modport slave (
        input  start, sym_valid, sym,
        output busy, sym_idx, pass, fail
    );
endinterface

// File: rtl/session_checker.sv
// session_checker: checks one session of four 2-bit symbols against CODE and
// emits a one-cycle pass or fail pulse when the fourth symbol is accepted.
// Optional idle timeout inside a session: define SESSION_CHECKER_TIMEOUT_EN.
module session_checker #(
    parameter logic [7:0]  CODE    = 8'b10_01_11_00,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic               clk_i,
    input  logic               rst_i,
    session_checker_if.slave   bus
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t     state_q, state_d;
    logic [1:0] sym_idx_q, sym_idx_d;
    logic       mis_q, mis_d;
    logic       pass_q, pass_d;
    logic       fail_q, fail_d;
    logic [1:0] exp_sym;
    logic       mis_new;
`ifdef SESSION_CHECKER_TIMEOUT_EN
    logic [7:0] timer_q, timer_d;
`endif

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range
        $error("session_checker: TIMEOUT must be in 1..255");
    end

    // Next-state and pulse generation for the session FSM
    always_comb begin
        state_d   = state_q;
        sym_idx_d = sym_idx_q;
        mis_d     = mis_q;
        pass_d    = 1'b0;
        fail_d    = 1'b0;
`ifdef SESSION_CHECKER_TIMEOUT_EN
        timer_d   = timer_q;
`endif
        exp_sym   = CODE[{sym_idx_q, 1'b0} +: 2];
        mis_new   = mis_q | (bus.sym != exp_sym);

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d   = ACTIVE;
                    sym_idx_d = '0;
                    mis_d     = 1'b0;
`ifdef SESSION_CHECKER_TIMEOUT_EN
                    timer_d   = '0;
`endif
                end
            end
            ACTIVE: begin
                if (bus.start) begin
                    sym_idx_d = '0;
                    mis_d     = 1'b0;
`ifdef SESSION_CHECKER_TIMEOUT_EN
                    timer_d   = '0;
`endif
                end else if (bus.sym_valid) begin
                    mis_d = mis_new;
`ifdef SESSION_CHECKER_TIMEOUT_EN
                    timer_d = '0;
`endif
                    if (sym_idx_q == 2'd3) begin
                        state_d   = IDLE;
                        sym_idx_d = '0;
                        pass_d    = ~mis_new;
                        fail_d    = mis_new;
                    end else begin
                        sym_idx_d = sym_idx_q + 2'd1;
                    end
                end else begin
`ifdef SESSION_CHECKER_TIMEOUT_EN
                    if (timer_q == 8'(TIMEOUT - 1)) begin
                        state_d   = IDLE;
                        sym_idx_d = '0;
                        fail_d    = 1'b1;
                    end else if (timer_q != '1) begin
                        timer_d = timer_q + 8'd1;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            sym_idx_q <= '0;
            mis_q     <= 1'b0;
            pass_q    <= 1'b0;
            fail_q    <= 1'b0;
`ifdef SESSION_CHECKER_TIMEOUT_EN
            timer_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            sym_idx_q <= sym_idx_d;
            mis_q     <= mis_d;
            pass_q    <= pass_d;
            fail_q    <= fail_d;
`ifdef SESSION_CHECKER_TIMEOUT_EN
            timer_q   <= timer_d;
`endif
        end
    end

    assign bus.busy    = (state_q == ACTIVE);
    assign bus.sym_idx = sym_idx_q;
    assign bus.pass    = pass_q;
    assign bus.fail    = fail_q;

endmodule

// File: tb/tb_session_checker.sv
// tb_session_checker: drives scripted and random sessions into session_checker
// and compares every cycle against a session-level reference model.
module tb_session_checker;

    localparam logic [7:0]  TB_CODE    = 8'b10_01_11_00;
    localparam int unsigned TB_TIMEOUT = 8;

    typedef struct packed {
        bit       r;
        bit       s;
        bit       v;
        bit [1:0] y;
    } stim_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    session_checker_if bus ();

    session_checker #(.CODE(TB_CODE), .TIMEOUT(TB_TIMEOUT)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: the session is the list of symbols accepted so far
    bit m_active;
    int m_syms[$];
    int m_idle;
    bit e_pass;
    bit e_fail;

    function automatic int code_sym(int k);
        return int'((TB_CODE >> (2 * k)) & 8'd3);
    endfunction

    function automatic void model_step(stim_t st);
        bit ok;
        e_pass = 1'b0;
        e_fail = 1'b0;
        if (st.r) begin
            m_active = 1'b0;
            m_syms.delete();
            m_idle = 0;
        end else if (st.s) begin
            m_active = 1'b1;
            m_syms.delete();
            m_idle = 0;
        end else if (m_active && st.v) begin
            m_syms.push_back(int'(st.y));
            m_idle = 0;
            if (m_syms.size() == 4) begin
                ok = 1'b1;
                for (int k = 0; k < 4; k++)
                    if (m_syms[k] != code_sym(k)) ok = 1'b0;
                e_pass   = ok;
                e_fail   = !ok;
                m_active = 1'b0;
                m_syms.delete();
            end
        end else if (m_active) begin
`ifdef SESSION_CHECKER_TIMEOUT_EN
            m_idle++;
            if (m_idle == int'(TB_TIMEOUT)) begin
                e_fail   = 1'b1;
                m_active = 1'b0;
                m_syms.delete();
            end
`endif
        end
    endfunction

    function automatic logic [4:0] exp_vec();
        logic [1:0] idx;
        idx = m_active ? 2'(m_syms.size()) : 2'b00;
        return {m_active, idx, e_pass, e_fail};
    endfunction

    function automatic stim_t mk(bit r, bit s, bit v, bit [1:0] y);
        stim_t st;
        st.r = r; st.s = s; st.v = v; st.y = y;
        return st;
    endfunction

    function automatic stim_t idle_c();
        return mk(1'b0, 1'b0, 1'b0, 2'($urandom_range(0, 3)));
    endfunction

    task automatic drive(stim_t st);
        rst           = st.r;
        bus.start     = st.s;
        bus.sym_valid = st.v;
        bus.sym       = st.y;
        model_step(st);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        stim_t q[$];
        for (int i = 0; i < 3; i++)
            q.push_back(mk(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3))));
        foreach (q[i]) begin
            drive(q[i]);
            checks++;
            if ({bus.busy, bus.sym_idx, bus.pass, bus.fail} !== exp_vec()) begin
                errors++;
                $display("FAIL reset[%0d]: busy,idx,pass,fail got %b expected %b", i, {bus.busy, bus.sym_idx, bus.pass, bus.fail}, exp_vec());
            end
        end
    endtask

    task automatic test_match();
        stim_t q[$];
        int np = 0, nf = 0;
        q.push_back(mk(0, 1, 0, 0));
        for (int k = 0; k < 4; k++) q.push_back(mk(0, 0, 1, 2'(code_sym(k))));
        q.push_back(idle_c());
        q.push_back(idle_c());
        foreach (q[i]) begin
            drive(q[i]);
            np += int'(bus.pass);
            nf += int'(bus.fail);
            checks++;
            if ({bus.busy, bus.sym_idx, bus.pass, bus.fail} !== exp_vec()) begin
                errors++;
                $display("FAIL match[%0d]: busy,idx,pass,fail got %b expected %b", i, {bus.busy, bus.sym_idx, bus.pass, bus.fail}, exp_vec());
            end
        end
        checks++;
        if (np != 1 || nf != 0) begin
            errors++;
            $display("FAIL match_count: pass=%0d fail=%0d expected pass=1 fail=0", np, nf);
        end
    endtask

    task automatic test_mismatch();
        stim_t q[$];
        int np = 0, nf = 0;
        bit [1:0] seq [4] = '{2'd0, 2'd2, 2'd1, 2'd2};
        q.push_back(mk(0, 1, 0, 0));
        for (int k = 0; k < 4; k++) begin
            q.push_back(mk(0, 0, 1, seq[k]));
            for (int g = $urandom_range(0, 3); g > 0; g--) q.push_back(idle_c());
        end
        q.push_back(idle_c());
        foreach (q[i]) begin
            drive(q[i]);
            np += int'(bus.pass);
            nf += int'(bus.fail);
            checks++;
            if ({bus.busy, bus.sym_idx, bus.pass, bus.fail} !== exp_vec()) begin
                errors++;
                $display("FAIL mismatch[%0d]: busy,idx,pass,fail got %b expected %b", i, {bus.busy, bus.sym_idx, bus.pass, bus.fail}, exp_vec());
            end
        end
        checks++;
        if (np != 0 || nf != 1) begin
            errors++;
            $display("FAIL mismatch_count: pass=%0d fail=%0d expected pass=0 fail=1", np, nf);
        end
    endtask

    task automatic test_restart();
        stim_t q[$];
        int np = 0, nf = 0;
        q.push_back(mk(0, 1, 0, 0));
        q.push_back(mk(0, 0, 1, 2'd0));
        q.push_back(mk(0, 0, 1, 2'd3));
        q.push_back(mk(0, 1, 1, 2'd1));
        for (int k = 0; k < 4; k++) q.push_back(mk(0, 0, 1, 2'(code_sym(k))));
        q.push_back(idle_c());
        foreach (q[i]) begin
            drive(q[i]);
            np += int'(bus.pass);
            nf += int'(bus.fail);
            checks++;
            if ({bus.busy, bus.sym_idx, bus.pass, bus.fail} !== exp_vec()) begin
                errors++;
                $display("FAIL restart[%0d]: busy,idx,pass,fail got %b expected %b", i, {bus.busy, bus.sym_idx, bus.pass, bus.fail}, exp_vec());
            end
        end
        checks++;
        if (np != 1 || nf != 0) begin
            errors++;
            $display("FAIL restart_count: pass=%0d fail=%0d expected pass=1 fail=0", np, nf);
        end
    endtask

    task automatic test_reset_mid();
        stim_t q[$];
        int np = 0, nf = 0;
        q.push_back(mk(0, 1, 0, 0));
        q.push_back(mk(0, 0, 1, 2'd0));
        q.push_back(mk(0, 0, 1, 2'd3));
        q.push_back(mk(0, 0, 1, 2'd1));
        q.push_back(mk(1, 0, 0, 2'd0));
        q.push_back(mk(0, 0, 1, 2'd2));
        q.push_back(idle_c());
        foreach (q[i]) begin
            drive(q[i]);
            np += int'(bus.pass);
            nf += int'(bus.fail);
            checks++;
            if ({bus.busy, bus.sym_idx, bus.pass, bus.fail} !== exp_vec()) begin
                errors++;
                $display("FAIL reset_mid[%0d]: busy,idx,pass,fail got %b expected %b", i, {bus.busy, bus.sym_idx, bus.pass, bus.fail}, exp_vec());
            end
        end
        checks++;
        if (np != 0 || nf != 0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_count: pass=%0d fail=%0d busy=%b expected 0 0 0", np, nf, bus.busy);
        end
    endtask

`ifdef SESSION_CHECKER_TIMEOUT_EN
    task automatic test_timeout();
        stim_t q[$];
        int np = 0, nf = 0;
        q.push_back(mk(0, 1, 0, 0));
        q.push_back(mk(0, 0, 1, 2'd0));
        for (int g = 0; g < int'(TB_TIMEOUT); g++) q.push_back(idle_c());
        q.push_back(idle_c());
        q.push_back(mk(0, 1, 0, 0));
        for (int k = 0; k < 4; k++) begin
            for (int g = 0; g < int'(TB_TIMEOUT) - 1; g++) q.push_back(idle_c());
            q.push_back(mk(0, 0, 1, 2'(code_sym(k))));
        end
        q.push_back(idle_c());
        foreach (q[i]) begin
            drive(q[i]);
            np += int'(bus.pass);
            nf += int'(bus.fail);
            checks++;
            if ({bus.busy, bus.sym_idx, bus.pass, bus.fail} !== exp_vec()) begin
                errors++;
                $display("FAIL timeout[%0d]: busy,idx,pass,fail got %b expected %b", i, {bus.busy, bus.sym_idx, bus.pass, bus.fail}, exp_vec());
            end
        end
        checks++;
        if (np != 1 || nf != 1) begin
            errors++;
            $display("FAIL timeout_count: pass=%0d fail=%0d expected pass=1 fail=1", np, nf);
        end
    endtask
`endif

    task automatic test_back_to_back();
        stim_t q[$];
        int np = 0, nf = 0;
        // four sessions, each start sampled in the previous session's pass cycle
        q.push_back(mk(0, 1, 0, 0));
        for (int s = 0; s < 4; s++) begin
            for (int k = 0; k < 4; k++) q.push_back(mk(0, 0, 1, 2'(code_sym(k))));
            q.push_back(mk(0, (s < 3) ? 1'b1 : 1'b0, 0, 0));
        end
        // one start, then three batches that arrive while IDLE
        q.push_back(mk(0, 1, 0, 0));
        for (int s = 0; s < 4; s++)
            for (int k = 0; k < 4; k++) q.push_back(mk(0, 0, 1, 2'(code_sym(k))));
        q.push_back(idle_c());
        foreach (q[i]) begin
            drive(q[i]);
            np += int'(bus.pass);
            nf += int'(bus.fail);
            checks++;
            if ({bus.busy, bus.sym_idx, bus.pass, bus.fail} !== exp_vec()) begin
                errors++;
                $display("FAIL b2b[%0d]: busy,idx,pass,fail got %b expected %b", i, {bus.busy, bus.sym_idx, bus.pass, bus.fail}, exp_vec());
            end
        end
        checks++;
        if (np != 5 || nf != 0) begin
            errors++;
            $display("FAIL b2b_count: pass=%0d fail=%0d expected pass=5 fail=0", np, nf);
        end
    endtask

    task automatic test_random();
        stim_t st;
        for (int i = 0; i < 400; i++) begin
            st.r = ($urandom_range(0, 63) == 0);
            st.s = ($urandom_range(0, 15) == 0);
            st.v = 1'($urandom_range(0, 1));
            st.y = ($urandom_range(0, 3) != 0) ? 2'(code_sym(m_syms.size() % 4)) : 2'($urandom_range(0, 3));
            drive(st);
            checks++;
            if ({bus.busy, bus.sym_idx, bus.pass, bus.fail} !== exp_vec()) begin
                errors++;
                $display("FAIL random[%0d]: busy,idx,pass,fail got %b expected %b", i, {bus.busy, bus.sym_idx, bus.pass, bus.fail}, exp_vec());
            end
        end
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.sym_valid = 1'b0;
        bus.sym       = 2'b00;
        m_active      = 1'b0;
        m_idle        = 0;
        e_pass        = 1'b0;
        e_fail        = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_match();
        test_mismatch();
        test_restart();
        test_reset_mid();
`ifdef SESSION_CHECKER_TIMEOUT_EN
        test_timeout();
`endif
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
